// File: rtl/sdff_pkg.sv
// Shared constants and helpers for the scan flip-flop bank.
package sdff_pkg;

  localparam int unsigned SCAN_DIR_UP   = 0;
  localparam int unsigned SCAN_DIR_DOWN = 1;

  // Counter width able to hold the values 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sdff_bit.sv
// Single scan flop with priority reset > shift > capture > hold.
module sdff_bit (
  input  logic CK,
  input  logic RST,
  input  logic RV,
  input  logic E,
  input  logic SE,
  input  logic SI,
  input  logic D,
  output logic Q,
  output logic QN
);

  always_ff @(posedge CK) begin
    if (RST)     Q <= RV;
    else if (SE) Q <= SI;
    else if (E)  Q <= D;
  end

  assign QN = ~Q;

endmodule

// File: rtl/sdff_bank.sv
// WIDTH-bit scannable register bank with one scan chain and a chain-load counter.
module sdff_bank
  import sdff_pkg::*;
#(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter int unsigned           SCAN_DIR    = SCAN_DIR_UP,
  localparam int unsigned          CW          = cnt_width(WIDTH)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             E,
  input  logic             SE,
  input  logic             SI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO,
  output logic [CW-1:0]    SHIFT_CNT,
  output logic             SHIFT_DONE
);

  logic [WIDTH-1:0] chain_in;

  // Each bit takes its scan input from its upstream neighbour, the chain head from SI.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (SCAN_DIR == SCAN_DIR_UP) begin : g_up
      if (i == 0) begin : g_head
        assign chain_in[i] = SI;
      end else begin : g_link
        assign chain_in[i] = Q[i-1];
      end
    end else begin : g_down
      if (i == WIDTH - 1) begin : g_head
        assign chain_in[i] = SI;
      end else begin : g_link
        assign chain_in[i] = Q[i+1];
      end
    end

    sdff_bit u_bit (
      .CK (CK),
      .RST(RST),
      .RV (RESET_VALUE[i]),
      .E  (E),
      .SE (SE),
      .SI (chain_in[i]),
      .D  (D[i]),
      .Q  (Q[i]),
      .QN (QN[i])
    );
  end

  if (SCAN_DIR == SCAN_DIR_UP) begin : g_so_up
    assign SO = Q[WIDTH-1];
  end else begin : g_so_down
    assign SO = Q[0];
  end

  // Consecutive shift count, saturating at WIDTH; any non-shift edge restarts it.
  always_ff @(posedge CK) begin
    if (RST) begin
      SHIFT_CNT <= '0;
    end else if (SE) begin
      if (SHIFT_CNT != CW'(WIDTH)) SHIFT_CNT <= SHIFT_CNT + CW'(1);
    end else begin
      SHIFT_CNT <= '0;
    end
  end

  assign SHIFT_DONE = (SHIFT_CNT == CW'(WIDTH));

endmodule

// File: tb/tb_sdff_bank.sv
// Directed and random checks of three sdff_bank configurations against a value-level model.
module tb_sdff_bank;

  logic       ck = 1'b0;
  logic       rst, e, se, si;
  logic [7:0] d;

  logic [7:0] q0, qn0, q1, qn1;
  logic       q2, qn2, so0, so1, so2, done0, done1, done2, cnt2;
  logic [3:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  sdff_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .SCAN_DIR(0)) dut0 (
    .CK(ck), .RST(rst), .E(e), .SE(se), .SI(si), .D(d),
    .Q(q0), .QN(qn0), .SO(so0), .SHIFT_CNT(cnt0), .SHIFT_DONE(done0));

  sdff_bank #(.WIDTH(8), .RESET_VALUE(8'h3C), .SCAN_DIR(1)) dut1 (
    .CK(ck), .RST(rst), .E(e), .SE(se), .SI(si), .D(d),
    .Q(q1), .QN(qn1), .SO(so1), .SHIFT_CNT(cnt1), .SHIFT_DONE(done1));

  sdff_bank #(.WIDTH(1), .RESET_VALUE(1'b1), .SCAN_DIR(0)) dut2 (
    .CK(ck), .RST(rst), .E(e), .SE(se), .SI(si), .D(d[0:0]),
    .Q(q2), .QN(qn2), .SO(so2), .SHIFT_CNT(cnt2), .SHIFT_DONE(done2));

  // Model state: register contents as a number and the current run of shift edges.
  int unsigned mw[3] = '{8, 8, 1};
  int unsigned md[3] = '{0, 1, 0};
  logic [63:0] mrv[3] = '{64'hA5, 64'h3C, 64'h1};
  logic [63:0] mq[3];
  int unsigned mc[3];

  logic [63:0] oq[3], oqn[3], oso[3], ocnt[3], odone[3];
  assign oq[0] = 64'(q0);  assign oqn[0] = 64'(qn0); assign oso[0] = 64'(so0);
  assign ocnt[0] = 64'(cnt0); assign odone[0] = 64'(done0);
  assign oq[1] = 64'(q1);  assign oqn[1] = 64'(qn1); assign oso[1] = 64'(so1);
  assign ocnt[1] = 64'(cnt1); assign odone[1] = 64'(done1);
  assign oq[2] = 64'(q2);  assign oqn[2] = 64'(qn2); assign oso[2] = 64'(so2);
  assign ocnt[2] = 64'(cnt2); assign odone[2] = 64'(done2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [63:0] mask;
      mask = (64'd1 << mw[k]) - 64'd1;
      if (rst) begin
        mq[k] = mrv[k];
        mc[k] = 0;
      end else if (se) begin
        if (md[k] == 0) mq[k] = ((mq[k] << 1) | 64'(si)) & mask;
        else            mq[k] = (mq[k] >> 1) | (64'(si) << (mw[k] - 1));
        if (mc[k] < mw[k]) mc[k] = mc[k] + 1;
      end else begin
        if (e) mq[k] = 64'(d) & mask;
        mc[k] = 0;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    for (int k = 0; k < 3; k++) begin
      logic [63:0] mask;
      mask = (64'd1 << mw[k]) - 64'd1;
      chk($sformatf("%s dut%0d q", ctx, k), oq[k], mq[k]);
      chk($sformatf("%s dut%0d qn", ctx, k), oqn[k], ~mq[k] & mask);
      chk($sformatf("%s dut%0d so", ctx, k), oso[k],
          (md[k] == 0) ? 64'((mq[k] >> (mw[k] - 1)) & 64'd1) : (mq[k] & 64'd1));
      chk($sformatf("%s dut%0d cnt", ctx, k), ocnt[k], 64'(mc[k]));
      chk($sformatf("%s dut%0d done", ctx, k), odone[k], 64'(mc[k] == mw[k]));
    end
  endtask

  task automatic tick(input string ctx);
    @(posedge ck);
    model_step();
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic [7:0] bits;
    bits = 8'b1011_0010;
    rst = 1'b1; e = 1'b1; se = 1'b1; si = 1'b0; d = 8'hFF;
    #1;

    // Reset wins over shift and capture.
    tick("reset");
    chk("reset q", 64'(q0), 64'hA5);
    chk("reset qn", 64'(qn0), 64'h5A);
    chk("reset so", 64'(so0), 64'h1);
    chk("reset cnt", 64'(cnt0), 64'h0);
    chk("reset done", 64'(done0), 64'h0);

    // Capture then hold.
    rst = 1'b0; se = 1'b0; e = 1'b1; d = 8'h3C;
    tick("capture");
    chk("capture q", 64'(q0), 64'h3C);
    e = 1'b0; d = 8'hFF;
    for (int i = 0; i < 3; i++) tick("hold");
    chk("hold q", 64'(q0), 64'h3C);

    // Full chain load from zero, MSB of the pattern first.
    e = 1'b1; d = 8'h00;
    tick("clear");
    se = 1'b1;
    for (int i = 0; i < 8; i++) begin
      si = bits[7-i];
      tick("load");
      chk($sformatf("load cnt %0d", i), 64'(cnt0), 64'(i + 1));
    end
    chk("load q", 64'(q0), 64'hB2);
    chk("load done", 64'(done0), 64'h1);
    si = 1'b0;
    tick("saturate");
    chk("saturate cnt", 64'(cnt0), 64'h8);
    chk("saturate done", 64'(done0), 64'h1);

    // Interrupted shift: capture edge clears the count.
    se = 1'b0; e = 1'b1; d = 8'h00;
    tick("pre-int");
    se = 1'b1; si = 1'b1;
    for (int i = 0; i < 5; i++) tick("int shift");
    se = 1'b0; d = 8'h11;
    tick("int capture");
    chk("int q", 64'(q0), 64'h11);
    chk("int cnt", 64'(cnt0), 64'h0);
    se = 1'b1;
    tick("int restart");
    chk("int restart cnt", 64'(cnt0), 64'h1);

    // Reset mid-shift discards the partial load.
    for (int i = 0; i < 3; i++) tick("mid shift");
    rst = 1'b1;
    tick("mid reset");
    chk("mid reset q", 64'(q0), 64'hA5);
    chk("mid reset cnt", 64'(cnt0), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick("reload");
    chk("reload done early", 64'(done0), 64'h0);
    tick("reload last");
    chk("reload done", 64'(done0), 64'h1);

    // Downward chain and single-bit bank.
    se = 1'b0; e = 1'b1; d = 8'h00;
    tick("dir clear");
    se = 1'b1; si = 1'b1;
    tick("dir shift");
    chk("dir1 q", 64'(q1), 64'h80);
    chk("dir1 so", 64'(so1), 64'h0);
    chk("w1 q", 64'(q2), 64'h1);
    chk("w1 done", 64'(done2), 64'h1);

    // Random traffic with long shift runs and occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 5) == 0) se = ~se;
      e  = 1'($urandom_range(0, 1));
      si = 1'($urandom_range(0, 1));
      d  = 8'($urandom());
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
